// File: rtl/kbonacci_pkg.sv
// Shared types and helpers for the k-bonacci generator: FSM state, order limit, seed values.
package kbonacci_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MAX_ORDER = 8;

    // T(i) for the initial window: T0=0, T1=1, T(i)=2^(i-2) beyond, clipped to the term width.
    function automatic logic [63:0] seed_term(input int i, input int width);
        logic [63:0] v;
        logic [63:0] mask;
        if (i == 0)      v = 64'd0;
        else if (i == 1) v = 64'd1;
        else             v = 64'd1 << (i - 2);
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return v & mask;
    endfunction

endpackage

// File: rtl/kbonacci_sum.sv
// Combinational sum of the term window with overflow detect and wrap/saturate select.
module kbonacci_sum
    import kbonacci_pkg::*;
#(
    parameter int ORDER = 3,
    parameter int WIDTH = 32
) (
    input  logic [ORDER-1:0][WIDTH-1:0] w_i,
    input  logic                        sat_i,
    output logic [WIDTH-1:0]            sum_o,
    output logic                        ovf_o
);

    // Three guard bits hold the sum of up to MAX_ORDER full-scale terms.
    localparam int SW = WIDTH + 3;

    logic [MAX_ORDER-1:0][SW-1:0] leaf;
    logic [3:0][SW-1:0]           lvl1;
    logic [1:0][SW-1:0]           lvl2;
    logic [SW-1:0]                total;

    for (genvar i = 0; i < MAX_ORDER; i++) begin : g_leaf
        if (i < ORDER) begin : g_used
            assign leaf[i] = {3'b000, w_i[i]};
        end else begin : g_pad
            assign leaf[i] = '0;
        end
    end

    for (genvar j = 0; j < 4; j++) begin : g_lvl1
        assign lvl1[j] = leaf[2*j] + leaf[2*j+1];
    end

    for (genvar j = 0; j < 2; j++) begin : g_lvl2
        assign lvl2[j] = lvl1[2*j] + lvl1[2*j+1];
    end

    assign total = lvl2[0] + lvl2[1];
    assign ovf_o = |total[SW-1:WIDTH];
    assign sum_o = (ovf_o && sat_i) ? {WIDTH{1'b1}} : total[WIDTH-1:0];

endmodule

// File: rtl/kbonacci_gen.sv
// k-bonacci term generator with valid/ready output, term limit and sticky overflow flag.
module kbonacci_gen
    import kbonacci_pkg::*;
#(
    parameter int ORDER = 3,
    parameter int WIDTH = 32,
    parameter int IDXW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            sat_mode,
    input  logic [IDXW-1:0] n_terms,
    input  logic            start,
    output logic [WIDTH-1:0] s,
    output logic            s_valid,
    input  logic            s_ready,
    output logic [IDXW-1:0] idx,
    output logic            ovf,
    output logic            done
);

    state_e                      state_q, state_d;
    logic [ORDER-1:0][WIDTH-1:0] w_q, w_d;
    logic [ORDER-1:0][WIDTH-1:0] seed;
    logic [IDXW-1:0]             idx_q, idx_d;
    logic                        ovf_q, ovf_d;
    logic [WIDTH-1:0]            sum;
    logic                        sum_ovf;
    logic                        last;

    for (genvar i = 0; i < ORDER; i++) begin : g_seed
        assign seed[i] = WIDTH'(seed_term(i, WIDTH));
    end

    kbonacci_sum #(
        .ORDER (ORDER),
        .WIDTH (WIDTH)
    ) u_sum (
        .w_i   (w_q),
        .sat_i (sat_mode),
        .sum_o (sum),
        .ovf_o (sum_ovf)
    );

    assign last = (n_terms != '0) && (idx_q == n_terms - IDXW'(1));

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        if (en) begin
            if (start) begin
                // Restart wins over any accept landing on the same edge.
                state_d = RUN;
                w_d     = seed;
                idx_d   = '0;
                ovf_d   = 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: state_d = RUN;
                    RUN: begin
                        if (s_ready) begin
                            if (last) begin
                                state_d = DONE;
                            end else begin
                                for (int i = 0; i < ORDER - 1; i++) begin
                                    w_d[i] = w_q[i+1];
                                end
                                w_d[ORDER-1] = sum;
                                idx_d        = idx_q + IDXW'(1);
                                ovf_d        = ovf_q | sum_ovf;
                            end
                        end
                    end
                    DONE: state_d = DONE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= seed;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign s       = w_q[0];
    assign s_valid = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign idx     = idx_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_kbonacci_gen.sv
// Directed checks of three generator configurations sharing one stimulus sequence.
module tb_kbonacci_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sat_mode;
    logic [15:0] n_terms;
    logic        start;
    logic        s_ready;

    logic [31:0] s3, s4;
    logic [7:0]  s2;
    logic        v3, v2, v4;
    logic [15:0] i3, i2, i4;
    logic        o3, o2, o4;
    logic        d3, d2, d4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    kbonacci_gen #(.ORDER(3), .WIDTH(32), .IDXW(16)) u3 (
        .clk(clk), .rst(rst), .en(en), .sat_mode(sat_mode), .n_terms(n_terms),
        .start(start), .s(s3), .s_valid(v3), .s_ready(s_ready), .idx(i3),
        .ovf(o3), .done(d3));

    kbonacci_gen #(.ORDER(2), .WIDTH(8), .IDXW(16)) u2 (
        .clk(clk), .rst(rst), .en(en), .sat_mode(sat_mode), .n_terms(n_terms),
        .start(start), .s(s2), .s_valid(v2), .s_ready(s_ready), .idx(i2),
        .ovf(o2), .done(d2));

    kbonacci_gen #(.ORDER(4), .WIDTH(32), .IDXW(16)) u4 (
        .clk(clk), .rst(rst), .en(en), .sat_mode(sat_mode), .n_terms(n_terms),
        .start(start), .s(s4), .s_valid(v4), .s_ready(s_ready), .idx(i4),
        .ovf(o4), .done(d4));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] tri_exp [0:20];
        logic [31:0] fib_exp [0:4];
        logic [31:0] tet_exp [0:8];
        int          k;
        int          cyc;
        logic        rdy;

        tri_exp = '{0, 1, 1, 2, 4, 7, 13, 24, 44, 81, 149, 274, 504, 927, 1705,
                    3136, 5768, 10609, 19513, 35890, 66012};
        fib_exp = '{0, 1, 1, 2, 3};
        tet_exp = '{0, 1, 1, 2, 4, 8, 15, 29, 56};

        rst = 1'b1; en = 1'b0; sat_mode = 1'b0; n_terms = '0; start = 1'b0; s_ready = 1'b1;
        step();
        chk("rst_s", s3, 0);
        chk("rst_valid", v3, 0);
        chk("rst_idx", i3, 0);
        chk("rst_ovf", o3, 0);
        chk("rst_done", d3, 0);

        // Tribonacci stream plus the 8-bit Fibonacci wrap on u2.
        rst = 1'b0; en = 1'b1;
        step();
        chk("first_valid", v3, 1);
        for (int n = 0; n <= 20; n++) begin
            chk($sformatf("tri_s%0d", n), s3, tri_exp[n]);
            chk($sformatf("tri_idx%0d", n), i3, n);
            if (n == 12) chk("wrap_ovf_before", o2, 0);
            if (n == 13) chk("wrap_s13", s2, 233);
            if (n == 14) begin
                chk("wrap_s14", s2, 121);
                chk("wrap_ovf_after", o2, 1);
            end
            step();
        end

        // Async reset between edges clears the sticky flag at once.
        rst = 1'b1;
        #1;
        chk("arst_ovf", o2, 0);
        chk("arst_s", s3, 0);
        chk("arst_idx", i3, 0);
        step();
        rst = 1'b0; sat_mode = 1'b1;
        step();
        for (int n = 0; n <= 16; n++) begin
            if (n == 13) chk("sat_s13", s2, 233);
            if (n >= 14) chk($sformatf("sat_s%0d", n), s2, 255);
            if (n == 14) chk("sat_ovf", o2, 1);
            step();
        end

        // Mid-run reset at idx 9, asserted between clock edges.
        rst = 1'b1;
        step();
        rst = 1'b0; sat_mode = 1'b0;
        step();
        for (int n = 0; n <= 9; n++) begin
            chk($sformatf("pre_s%0d", n), s3, tri_exp[n]);
            if (n < 9) step();
        end
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_s", s3, 0);
        chk("mid_rst_valid", v3, 0);
        chk("mid_rst_idx", i3, 0);
        chk("mid_rst_ovf", o3, 0);
        step();
        chk("hold_rst_valid", v3, 0);
        rst = 1'b0;
        step();
        chk("restart_valid", v3, 1);
        chk("restart_s", s3, 0);
        chk("restart_idx", i3, 0);
        step();
        chk("restart_s1", s3, 1);
        chk("restart_idx1", i3, 1);

        // Enable low freezes the stream.
        repeat (4) step();
        chk("pre_en_s", s3, 7);
        en = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            chk($sformatf("en0_s%0d", n), s3, 7);
            chk($sformatf("en0_idx%0d", n), i3, 5);
        end
        en = 1'b1;
        step();
        chk("en_resume_s", s3, 13);
        chk("en_resume_idx", i3, 6);

        // Term limit of 5 on the Fibonacci instance, then restart.
        n_terms = 16'd5; start = 1'b1;
        step();
        start = 1'b0;
        chk("lim_start_s", s2, 0);
        chk("lim_start_idx", i2, 0);
        chk("lim_start_done", d2, 0);
        for (int n = 0; n < 5; n++) begin
            chk($sformatf("lim_s%0d", n), s2, fib_exp[n]);
            chk($sformatf("lim_idx%0d", n), i2, n);
            step();
        end
        chk("lim_valid", v2, 0);
        chk("lim_done", d2, 1);
        step();
        step();
        chk("lim_hold_valid", v2, 0);
        chk("lim_hold_done", d2, 1);
        chk("lim_hold_s", s2, 3);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("relaunch_s", s2, 0);
        chk("relaunch_idx", i2, 0);
        chk("relaunch_done", d2, 0);
        chk("relaunch_valid", v2, 1);

        // Back-pressure on the order-4 instance.
        n_terms = '0; start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 9 && cyc < 300) begin
            rdy = (cyc % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            s_ready = rdy;
            if (rdy && v4) begin
                chk($sformatf("bp_s%0d", k), s4, tet_exp[k]);
                chk($sformatf("bp_idx%0d", k), i4, k);
                k++;
            end
            step();
            cyc++;
        end
        chk("bp_count", k, 9);
        s_ready = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
